// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM capture path.
package pwm_pkg;

    typedef enum logic [0:0] {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int SAMPLES_PER_WORD = 8;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pwm_edge_find.sv
// Combinational rising-edge finder for one 8-sample word (bit 0 earliest).
module pwm_edge_find
    import pwm_pkg::*;
(
    input  logic [7:0] sample_d,
    input  logic       prev_bit,
    output logic [2:0] p,
    output logic [3:0] nedge,
    output logic [3:0] pc_lo,
    output logic [3:0] pc_hi
);

    logic [7:0] rise;
    logic [7:0] lo_mask;

    always_comb begin
        rise  = sample_d & ~{sample_d[6:0], prev_bit};
        nedge = popcount8(rise);
        p     = '0;
        for (int i = 7; i >= 0; i--) begin
            if (rise[i]) p = 3'(i);
        end
        // samples strictly before the first edge belong to the closing period
        lo_mask = (8'd1 << p) - 8'd1;
        pc_lo   = popcount8(sample_d & lo_mask);
        pc_hi   = popcount8(sample_d & ~lo_mask);
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time at sample resolution from 1:8 deserialized words.
//   state   | meaning
//   SEEK    | waiting for a single clean rising edge to arm a measurement
//   MEASURE | accumulating period/high samples since the last rising edge
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter int unsigned MAX_PERIOD = 'hFFFF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [7:0]       sample_d,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             result_valid,
    output logic             timeout,
    output logic             glitch
);

    state_t           state;
    logic             prev_bit;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] hacc;

    logic [2:0]       p;
    logic [3:0]       nedge;
    logic [3:0]       pc_lo;
    logic [3:0]       pc_hi;
    logic [CNT_W:0]   acc_next;

    pwm_edge_find u_edge_find (
        .sample_d (sample_d),
        .prev_bit (prev_bit),
        .p        (p),
        .nedge    (nedge),
        .pc_lo    (pc_lo),
        .pc_hi    (pc_hi)
    );

    // one bit wider so the timeout compare cannot wrap near the counter limit
    assign acc_next = {1'b0, acc} + (CNT_W+1)'(SAMPLES_PER_WORD);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= SEEK;
            prev_bit     <= 1'b0;
            acc          <= '0;
            hacc         <= '0;
            period       <= '0;
            high_time    <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            glitch       <= 1'b0;
        end else begin
            prev_bit     <= sample_d[7];
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            glitch       <= 1'b0;
            if (!en) begin
                state <= SEEK;
                acc   <= '0;
                hacc  <= '0;
            end else if (nedge > 4'd1) begin
                glitch <= 1'b1;
                state  <= SEEK;
                acc    <= '0;
                hacc   <= '0;
            end else if (state == SEEK) begin
                if (nedge == 4'd1) begin
                    acc   <= CNT_W'(SAMPLES_PER_WORD) - CNT_W'(p);
                    hacc  <= CNT_W'(pc_hi);
                    state <= MEASURE;
                end
            end else if (nedge == 4'd1) begin
                period       <= acc + CNT_W'(p);
                high_time    <= hacc + CNT_W'(pc_lo);
                result_valid <= 1'b1;
                acc          <= CNT_W'(SAMPLES_PER_WORD) - CNT_W'(p);
                hacc         <= CNT_W'(pc_hi);
            end else if (acc_next >= (CNT_W+1)'(MAX_PERIOD)) begin
                timeout <= 1'b1;
                state   <= SEEK;
                acc     <= '0;
                hacc    <= '0;
            end else begin
                acc  <= acc_next[CNT_W-1:0];
                hacc <= hacc + CNT_W'(popcount8(sample_d));
            end
        end
    end

endmodule
